reg_file_wr_arbiter: RTL and testbench
======================================

Name: reg_file_wr_arbiter

Overview:
- Shares the single register-file write port (A3/WE3/WD3) between NUM_REQ writeback requesters, e.g. ALU, load unit and multiply/divide unit.
- Uses per-requester valid/ready handshakes and a round-robin grant.
- Drives the port from a one-deep registered stage, so there is exactly one write per cycle at most.
- Sits between the writeback stage and the register file.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- ADDR_W, 5, register address width.
- DATA_W, 32, write data width.

Ports:
- Reg_File_CLK  input  1  clock.
- Reg_File_RST  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester write request.
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
- req_addr  input  NUM_REQ*ADDR_W  flattened destination addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data  input  NUM_REQ*DATA_W  flattened write data, same packing.
- wr_hold  input  1  freezes all grants while high.
- A3  output  ADDR_W  register-file write address.
- WE3  output  1  register-file write enable.
- WD3  output  DATA_W  register-file write data.
- grant_id  output  3  index of the requester whose write is on the port this cycle.

Behaviour:
- Reset (asynchronous, Reg_File_RST low):
  - WE3=0, A3=0, WD3=0, grant_id=0.
  - Round-robin pointer ptr=0.
  - Any staged write is dropped.
  - req_ready=0 while reset is asserted.
- Arbitration (combinational, same cycle):
  - If wr_hold=0, the first requester with req_valid=1 scanning ptr, ptr+1, … (mod NUM_REQ) gets req_ready=1.
  - If wr_hold=1, or no requester is valid, req_ready=0.
  - req_ready never depends on the granted requester's own req_data or req_addr.
- Handshake: a transfer occurs when req_valid[i] and req_ready[i] are both 1. The requester must hold valid, addr and data stable until accepted.
- Pointer update: on a transfer from i, ptr <= (i+1) mod NUM_REQ. With no transfer, ptr holds.
- Output stage (latency exactly 1 cycle):
  - On the edge after a transfer, A3/WD3/grant_id take the granted values.
  - WE3=1 unless the address is 0.
  - With no transfer, WE3<=0 and A3/WD3/grant_id hold their previous values.
- Register 0:
  - A transfer with address 0 completes normally: ready=1 and ptr advances.
  - WE3 stays 0 for it, and A3/WD3 still update.
- wr_hold:
  - Asserting it mid-stream still lets an already-staged write drive WE3 on the next cycle.
  - No new grants are issued while it is high.
  - ptr is preserved across the hold.
- Simultaneous requests:
  - Exactly one is granted per cycle.
  - With all NUM_REQ valid continuously, grants rotate strictly and each requester is served every NUM_REQ cycles.
- Reset mid-operation: a write accepted in the reset cycle is lost, and the requester is not re-signalled.
- No FSM beyond the ptr register and the staging register; the stage is always drained since the register file accepts every cycle.

Optional Feature:
- Macro: REG_WR_FWD_EN.
- Defined: adds these ports:
  - A1, A2: inputs, ADDR_W.
  - RD1_in, RD2_in: inputs, DATA_W, from the register file.
  - RD1_fwd, RD2_fwd: outputs, DATA_W.
- Bypass rule: RDn_fwd = WD3 when WE3=1 and A3 equals An (An≠0); otherwise RDn_in. This is purely combinational.
- It covers the write-then-read-same-cycle window.
- Undefined: these ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package reg_wr_arb_pkg holds:
  - REG_ADDR_W=5, REG_DATA_W=32.
  - ZERO_REG=5'd0.
  - GRANT_W=3.
  - A function mapping a one-hot grant to a grant index.
- Sub-module rr_arbiter (parameter N) takes inputs req[N], hold and ptr.
  - Outputs: one-hot gnt[N] and next_ptr.
  - The top level owns ptr, the staging register and the optional bypass.

Test Plan:
- Reset then single request: requester 1 valid with addr=5, data=0xDEADBEEF → ready[1]=1 the same cycle; next cycle WE3=1, A3=5, WD3=0xDEADBEEF, grant_id=1; the cycle after, WE3=0.
- All three valid for 6 cycles with ptr=0 → grant order 0,1,2,0,1,2, and WE3=1 on every cycle from cycle 2 through cycle 7.
- Register-0 discard: requester 2 with addr=0, data=0x1234 → ready[2]=1 and ptr becomes 0; next cycle WE3=0, A3=0.
- wr_hold asserted 3 cycles while requester 0 is valid → ready=0 throughout, WE3=0 from the second hold cycle, ptr unchanged; on release, requester 0 is granted immediately.
- Reset asserted asynchronously between clock edges while WE3=1 → WE3, A3 and WD3 go to 0 before the next edge; after release, ptr=0 and requester 0 has priority.
- REG_WR_FWD_EN: WE3=1, A3=7, WD3=0xA5A5A5A5 with A1=7, A2=8, RD1_in=0, RD2_in=0x11 → RD1_fwd=0xA5A5A5A5, RD2_fwd=0x11. With A1=0 and A3=0 there is no bypass.

Source files
------------

// File: rtl/reg_file_wr_arbiter_pkg.sv
// Shared constants and helpers for the register-file write-port arbiter.
// Included by rr_arbiter and reg_file_wr_arbiter via import reg_wr_arb_pkg::*.
package reg_wr_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int GRANT_W    = 3;
    localparam int MAX_REQ    = 8;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    // OR-reduction encoder: exact for a one-hot input, zero for an all-zero input.
    function automatic logic [GRANT_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [GRANT_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = idx | GRANT_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/reg_file_wr_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: scans req starting at ptr and returns a
// one-hot grant plus the pointer value that follows that grant.
module rr_arbiter
    import reg_wr_arb_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]       req,
    input  logic               hold,
    input  logic [GRANT_W-1:0] ptr,
    output logic [N-1:0]       gnt,
    output logic [GRANT_W-1:0] next_ptr
);

    logic [2*N-1:0] rotated;
    logic           found;
    int             sel;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt      = '0;
        next_ptr = ptr;
        found    = 1'b0;
        sel      = 0;
        // Bit k of rotated is requester (ptr + k) mod N.
        rotated  = {req, req} >> ptr;
        for (int k = 0; k < N; k++) begin
            if (!hold && !found && rotated[k]) begin
                found = 1'b1;
                sel   = int'(ptr) + k;
                if (sel >= N) sel = sel - N;
                gnt      = N'(1) << sel;
                next_ptr = (sel == N - 1) ? '0 : GRANT_W'(sel + 1);
            end
        end
    end

endmodule

// File: rtl/reg_file_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port A3/WE3/WD3 among
// NUM_REQ writeback requesters through a one-deep registered stage.
// Optional read bypass enabled by defining REG_WR_FWD_EN.
module reg_file_wr_arbiter
    import reg_wr_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int DATA_W  = REG_DATA_W
) (
    input  logic                      Reg_File_CLK,
    input  logic                      Reg_File_RST,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      wr_hold,
    output logic [ADDR_W-1:0]         A3,
    output logic                      WE3,
    output logic [DATA_W-1:0]         WD3,
`ifdef REG_WR_FWD_EN
    input  logic [ADDR_W-1:0]         A1,
    input  logic [ADDR_W-1:0]         A2,
    input  logic [DATA_W-1:0]         RD1_in,
    input  logic [DATA_W-1:0]         RD2_in,
    output logic [DATA_W-1:0]         RD1_fwd,
    output logic [DATA_W-1:0]         RD2_fwd,
`endif
    output logic [GRANT_W-1:0]        grant_id
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [GRANT_W-1:0] ptr;
    logic [GRANT_W-1:0] next_ptr;
    logic [NUM_REQ-1:0] gnt;
    logic               transfer;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic [GRANT_W-1:0] sel_id;

    rr_arbiter #(
        .N        (NUM_REQ)
    ) u_rr_arbiter (
        .req      (req_valid),
        .hold     (wr_hold),
        .ptr      (ptr),
        .gnt      (gnt),
        .next_ptr (next_ptr)
    );

    // Ready is suppressed while reset is held so no requester sees a phantom accept.
    assign req_ready = gnt & {NUM_REQ{Reg_File_RST}};
    assign transfer  = |req_ready;
    assign sel_id    = onehot_to_idx(MAX_REQ'(gnt));

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Reg_File_CLK or negedge Reg_File_RST) begin
        if (!Reg_File_RST) begin
            ptr      <= '0;
            WE3      <= 1'b0;
            A3       <= '0;
            WD3      <= '0;
            grant_id <= '0;
        end else begin
            ptr <= next_ptr;
            if (transfer) begin
                // A write to register 0 is accepted but never reaches the file.
                WE3      <= (sel_addr != ZERO_ADDR);
                A3       <= sel_addr;
                WD3      <= sel_data;
                grant_id <= sel_id;
            end else begin
                WE3 <= 1'b0;
            end
        end
    end

`ifdef REG_WR_FWD_EN
    // Bypass covers a read of the register being written in this same cycle.
    assign RD1_fwd = (WE3 && (A1 == A3) && (A1 != ZERO_ADDR)) ? WD3 : RD1_in;
    assign RD2_fwd = (WE3 && (A2 == A3) && (A2 != ZERO_ADDR)) ? WD3 : RD2_in;
`endif

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// Self-checking bench for reg_file_wr_arbiter: directed scenarios plus a
// randomized run compared against a behavioural round-robin model.
module tb_reg_file_wr_arbiter;
    import reg_wr_arb_pkg::*;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      valid;
    logic [N-1:0]      ready;
    logic [N*AW-1:0]   addr;
    logic [N*DW-1:0]   data;
    logic              hold;
    logic [AW-1:0]     a3;
    logic              we3;
    logic [DW-1:0]     wd3;
    logic [GRANT_W-1:0] gid;
`ifdef REG_WR_FWD_EN
    logic [AW-1:0]     a1, a2;
    logic [DW-1:0]     rd1_in, rd2_in, rd1_fwd, rd2_fwd;
`endif

    always #5 clk = ~clk;

    reg_file_wr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .Reg_File_CLK (clk),
        .Reg_File_RST (rst),
        .req_valid    (valid),
        .req_ready    (ready),
        .req_addr     (addr),
        .req_data     (data),
        .wr_hold      (hold),
        .A3           (a3),
        .WE3          (we3),
        .WD3          (wd3),
`ifdef REG_WR_FWD_EN
        .A1           (a1),
        .A2           (a2),
        .RD1_in       (rd1_in),
        .RD2_in       (rd2_in),
        .RD1_fwd      (rd1_fwd),
        .RD2_fwd      (rd2_fwd),
`endif
        .grant_id     (gid)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: abstract pointer and the value the write port should show.
    int            m_ptr;
    bit            m_we;
    logic [AW-1:0] m_a3;
    logic [DW-1:0] m_wd;
    int            m_gid;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int model_grant();
        if (hold) return -1;
        for (int k = 0; k < N; k++) begin
            if (valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_we = 0; m_a3 = '0; m_wd = '0; m_gid = 0;
    endtask

    task automatic set_req(input int i, input bit v, input logic [AW-1:0] ad, input logic [DW-1:0] dt);
        valid[i]          = v;
        addr[i*AW +: AW]  = ad;
        data[i*DW +: DW]  = dt;
    endtask

    // One clock: check combinational ready, take the edge, check the write port.
    task automatic step(input string tag, output int g);
        logic [N-1:0] exp_rdy;
        #1;
        g = model_grant();
        exp_rdy = (g < 0) ? '0 : N'(1) << g;
        check({tag, "_ready"}, 64'(ready), 64'(exp_rdy));
        check({tag, "_we_pre"}, 64'(we3), 64'(m_we));
        @(posedge clk);
        if (g >= 0) begin
            m_a3  = addr[g*AW +: AW];
            m_wd  = data[g*DW +: DW];
            m_gid = g;
            m_we  = (m_a3 != 0);
            m_ptr = (g + 1) % N;
        end else begin
            m_we = 0;
        end
        #1;
        check({tag, "_we"},  64'(we3), 64'(m_we));
        check({tag, "_a3"},  64'(a3),  64'(m_a3));
        check({tag, "_wd3"}, 64'(wd3), 64'(m_wd));
        check({tag, "_gid"}, 64'(gid), 64'(m_gid));
    endtask

    // Asynchronous reset pulse while the clock is high, released before the next edge.
    task automatic async_reset(input string tag);
        #2 rst = 1'b0;
        #1;
        check({tag, "_we"},    64'(we3),   64'd0);
        check({tag, "_a3"},    64'(a3),    64'd0);
        check({tag, "_wd3"},   64'(wd3),   64'd0);
        check({tag, "_ready"}, 64'(ready), 64'd0);
        model_reset();
        #1 rst = 1'b1;
    endtask

    initial begin
        int g;
        bit [N-1:0] pend;

        valid = '0; addr = '0; data = '0; hold = 1'b0;
`ifdef REG_WR_FWD_EN
        a1 = '0; a2 = '0; rd1_in = '0; rd2_in = '0;
`endif
        rst = 1'b0;
        model_reset();
        valid = '1;
        #2;
        check("rst_we",    64'(we3),   64'd0);
        check("rst_a3",    64'(a3),    64'd0);
        check("rst_wd3",   64'(wd3),   64'd0);
        check("rst_gid",   64'(gid),   64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        valid = '0;
        @(negedge clk) rst = 1'b1;

        // Single request from requester 1.
        set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
        step("single", g);
        set_req(1, 1'b0, 5'd0, 32'h0);
        step("single_idle", g);
        check("single_we_drop", 64'(we3), 64'd0);

        // All three valid from ptr=0: strict rotation 0,1,2,0,1,2.
        async_reset("rst_mid");
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 1 + 3 * c), 32'hC000_0000 + c * 16 + i);
            step("rotate", g);
            check("rotate_order", 64'(gid), 64'(c % 3));
            check("rotate_we", 64'(we3), 64'd1);
        end

        // Register-0 discard from requester 2, then ptr must sit on 0.
        valid = '0;
        set_req(2, 1'b1, 5'd0, 32'h1234);
        step("reg0", g);
        check("reg0_we", 64'(we3), 64'd0);
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'd10, 32'h5555_0000 + i);
        step("reg0_ptr", g);
        check("reg0_next_gid", 64'(gid), 64'd0);

        // Stage a write from requester 1, then hold three cycles with requester 0 waiting.
        valid = '0;
        set_req(1, 1'b1, 5'd9, 32'hBEEF_0009);
        step("pre_hold", g);
        set_req(1, 1'b0, 5'd0, 32'h0);
        set_req(0, 1'b1, 5'd3, 32'h0000_0A03);
        hold = 1'b1;
        for (int c = 0; c < 3; c++) step("hold", g);
        hold = 1'b0;
        step("hold_rel", g);
        check("hold_rel_gid", 64'(gid), 64'd0);

        // Async reset while WE3 is high; requester 0 must win afterwards.
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(20 + i), 32'h7700_0000 + i);
        step("pre_rst", g);
        step("pre_rst2", g);
        check("pre_rst_we", 64'(we3), 64'd1);
        async_reset("rst_async");
        step("post_rst", g);
        check("post_rst_gid", 64'(gid), 64'd0);

`ifdef REG_WR_FWD_EN
        valid = '0;
        set_req(0, 1'b1, 5'd7, 32'hA5A5A5A5);
        step("fwd_wr", g);
        a1 = 5'd7; a2 = 5'd8; rd1_in = 32'h0; rd2_in = 32'h11;
        #1;
        check("fwd_rd1", 64'(rd1_fwd), 64'hA5A5A5A5);
        check("fwd_rd2", 64'(rd2_fwd), 64'h11);
        set_req(0, 1'b1, 5'd0, 32'hFFFF0000);
        step("fwd_z", g);
        a1 = 5'd0; rd1_in = 32'h22;
        #1;
        check("fwd_zero", 64'(rd1_fwd), 64'h22);
`endif

        // Randomized traffic: requesters keep addr/data stable until accepted.
        valid = '0; hold = 1'b0; pend = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    set_req(i, 1'($urandom_range(0, 1)),
                            ($urandom_range(0, 5) == 0) ? AW'(0) : AW'($urandom_range(1, 31)),
                            DW'($urandom));
                end
            end
            hold = ($urandom_range(0, 5) == 0);
            step("rnd", g);
            for (int i = 0; i < N; i++) pend[i] = valid[i] && (i != g);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
